acc_feeder: RTL
===============

// Module: acc_feeder
// PURPOSE
//  Upstream transmitter for the acc_pipe input port. Accepts a byte-serial signed sample stream
//  under valid/ready and packs each run of 4 samples into one vector on X1..X4. Presents the
//  vector to acc_pipe with valid, honouring its ready. An assembly register plus an output
//  register let the next vector fill while the current one waits, so a ready-tied-high
//  accelerator sees 1 vector per 4 input beats with no bubbles.
// PARAMETERS
//  W      8   sample width in bits; samples are signed two's complement
//  CNT_W  16  width of vec_count
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  arst       in   1      reset; synchronous, active-high
//  s_data     in   W      signed input sample
//  s_valid    in   1      s_data valid
//  s_last     in   1      marks the final sample of a frame; flushes a partial vector
//  s_ready    out  1      feeder can accept a sample this cycle
//  X1..X4     out  W      signed vector lanes to acc_pipe; X1 = first sample received
//  valid      out  1      X1..X4 hold a vector; connects to acc_pipe valid
//  ready      in   1      acc_pipe ready; transfer when valid && ready at posedge
//  vec_count  out  CNT_W  number of vectors transferred to acc_pipe
// BEHAVIOUR
//  Reset (arst=1 at posedge): lane idx=0, asm regs=0, X1..X4=0, valid=0, vec_count=0, state=FILL.
//   Reset overrides every other event in that cycle. A partial vector or a pending output is
//   discarded.
//  Input accept: a beat is accepted when s_valid && s_ready. The sample is written to assembly
//   lane idx, and idx advances 0..3.
//  A vector is complete on the accepted beat where idx==3 or s_last==1.
//   On s_last with idx<3, the lanes above idx are zero-filled. idx then returns to 0.
//  Output slot free this cycle: out_free = !valid || ready.
//  FSM has 2 states:
//   FILL: s_ready=1.
//    - On a completing beat with out_free=1: X1..X4 load the completed vector, including the
//      current sample, at that posedge. valid=1 from the next cycle. Stay in FILL.
//    - On a completing beat with out_free=0: the vector stays in the assembly regs. Go to WAIT.
//   WAIT: s_ready=0. No samples are accepted.
//    - When out_free=1: the assembly regs transfer to X1..X4, valid stays or becomes 1, and the
//      state returns to FILL.
//  Output handshake: at each posedge with valid && ready:
//   - vec_count increments by 1; wraps 2^CNT_W-1 -> 0.
//   - valid clears unless a new vector loads in the same cycle. A load in the same cycle takes
//     priority and keeps valid=1.
//  While valid=1 && ready=0, X1..X4 and valid hold stable (AXI-style: no retraction).
//  Latency: the completing beat is accepted at edge k and valid=1 is visible after edge k
//   (0-cycle bubble). WAIT adds one cycle per blocked vector beyond the release cycle.
//  s_ready depends only on registered state, not combinationally on ready.
//  s_last on idx==3 behaves as a normal completion with no zero lanes.
//  s_last with s_valid=0 is ignored.
//  No arithmetic; samples pass through bit-exact, sign preserved.
// TESTING
//  1 ready=1; stream 1,-2,3,-4,5,6,7,8 -> vectors (1,-2,3,-4),(5,6,7,8); valid high for 1 cycle each; vec_count=2
//  2 ready=0; stream 8 samples 10..17 -> out=(10,11,12,13) held, s_ready=0 after 8th beat; raise ready -> (14,15,16,17) next, vec_count=2
//  3 stream -128,127 with s_last on 127 -> vector (-128,127,0,0); next stream 1,2,3,4 -> (1,2,3,4), lane order restarts at X1
//  4 ready toggles 1/0 every cycle, 400 random samples from file -> 100 vectors match golden file, zero mismatches, X stable while stalled
//  5 arst=1 for 1 cycle after 2 samples, with an output pending -> valid=0, X=0, vec_count=0; next 4 samples form a clean vector
//  6 preload vec_count to 16'hFFFF via 65535 transfers (or CNT_W=4 build: 15) -> one more transfer wraps to 0

Source files
------------

// File: rtl/acc_feeder.sv
// Byte-serial to 4-lane vector packer feeding acc_pipe under valid/ready.
// An assembly stage fills while the output stage waits, so a ready-high sink sees no bubbles.
module acc_feeder #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                arst,
  input  logic signed [W-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic signed [W-1:0] X1,
  output logic signed [W-1:0] X2,
  output logic signed [W-1:0] X3,
  output logic signed [W-1:0] X4,
  output logic                valid,
  input  logic                ready,
  output logic [CNT_W-1:0]    vec_count
);

  typedef enum logic {FILL, WAIT} state_t;

  state_t                state;
  logic [1:0]            idx_p0;
  logic signed [W-1:0]   lane_p0 [4];
  logic signed [W-1:0]   vec_nxt [4];
  logic                  out_free;
  logic                  accept;
  logic                  complete;

  // Lane j of the vector completed by this beat: earlier lanes, current sample, then zero fill.
  function automatic logic signed [W-1:0] pick_lane(input logic [1:0] j,
                                                    input logic [1:0] idx,
                                                    input logic signed [W-1:0] held,
                                                    input logic signed [W-1:0] sample);
    if (j < idx)       return held;
    else if (j == idx) return sample;
    else               return '0;
  endfunction

  assign s_ready = (state == FILL);

  always_comb begin
    out_free = !valid || ready;
    accept   = s_valid && (state == FILL);
    complete = accept && ((idx_p0 == 2'd3) || s_last);
    for (int j = 0; j < 4; j++) begin
      vec_nxt[j] = pick_lane(2'(j), idx_p0, lane_p0[j], s_data);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= FILL;
      idx_p0    <= '0;
      for (int j = 0; j < 4; j++) lane_p0[j] <= '0;
      X1        <= '0;
      X2        <= '0;
      X3        <= '0;
      X4        <= '0;
      valid     <= 1'b0;
      vec_count <= '0;
    end else begin
      if (valid && ready) begin
        vec_count <= vec_count + CNT_W'(1);
        valid     <= 1'b0;
      end
      // A load below overrides the clear above so a back-to-back vector keeps valid high.
      case (state)
        FILL: begin
          if (accept) begin
            if (complete) begin
              idx_p0 <= '0;
              for (int j = 0; j < 4; j++) lane_p0[j] <= vec_nxt[j];
              if (out_free) begin
                X1    <= vec_nxt[0];
                X2    <= vec_nxt[1];
                X3    <= vec_nxt[2];
                X4    <= vec_nxt[3];
                valid <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end else begin
              lane_p0[idx_p0] <= s_data;
              idx_p0          <= idx_p0 + 2'd1;
            end
          end
        end
        WAIT: begin
          if (out_free) begin
            X1    <= lane_p0[0];
            X2    <= lane_p0[1];
            X3    <= lane_p0[2];
            X4    <= lane_p0[3];
            valid <= 1'b1;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
